// File: rtl/vga_pkg.sv
// Shared VGA coordinate type and 800x600@60 raster timing (40 MHz pixel clock).
package vga_pkg;

    typedef logic [10:0] vga_coord_t;

    localparam vga_coord_t HOR_PIXELS      = 11'd800;
    localparam vga_coord_t VER_PIXELS      = 11'd600;

    localparam vga_coord_t HOR_TOTAL_TIME  = 11'd1056;
    localparam vga_coord_t HOR_BLANK_START = 11'd800;
    localparam vga_coord_t HOR_SYNC_START  = 11'd840;
    localparam vga_coord_t HOR_SYNC_TIME   = 11'd128;

    localparam vga_coord_t VER_TOTAL_TIME  = 11'd628;
    localparam vga_coord_t VER_BLANK_START = 11'd600;
    localparam vga_coord_t VER_SYNC_START  = 11'd601;
    localparam vga_coord_t VER_SYNC_TIME   = 11'd4;

    localparam logic [11:0] RGB_BLACK      = 12'h000;

endpackage

// File: rtl/vga_if.sv
// Raster bundle passed between display pipeline stages.
interface vga_if;
    import vga_pkg::*;

    vga_coord_t  hcount;
    vga_coord_t  vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered blank/sync window flags.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_coord_t TOTAL       = HOR_TOTAL_TIME,
    parameter vga_coord_t BLANK_START = HOR_BLANK_START,
    parameter vga_coord_t SYNC_START  = HOR_SYNC_START,
    parameter vga_coord_t SYNC_TIME   = HOR_SYNC_TIME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv_i,
    output vga_coord_t cnt_o,
    output logic       blank_o,
    output logic       sync_o,
    output logic       wrap_o
);

    vga_coord_t cnt_q, cnt_d;
    logic       blank_q, blank_d;
    logic       sync_q, sync_d;

    assign wrap_o = adv_i && (cnt_q == TOTAL - 11'd1);

    // Flags are derived from the next count so they land in the same edge as it.
    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 11'd1;
        end
        blank_d = (cnt_d >= BLANK_START);
        sync_d  = (cnt_d >= SYNC_START) && (cnt_d < SYNC_START + SYNC_TIME);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            blank_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign blank_o = blank_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source with frame-start strobe.
// Optional completed-frame counter output enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    vga_if.out          out,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    vga_coord_t hcount, vcount;
    logic       hblnk, hsync, h_wrap;
    logic       vblnk, vsync, v_wrap;
    logic       frame_start_q, frame_start_d;

    vga_axis_counter #(
        .TOTAL       (HOR_TOTAL_TIME),
        .BLANK_START (HOR_BLANK_START),
        .SYNC_START  (HOR_SYNC_START),
        .SYNC_TIME   (HOR_SYNC_TIME)
    ) u_hcnt (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (en),
        .cnt_o   (hcount),
        .blank_o (hblnk),
        .sync_o  (hsync),
        .wrap_o  (h_wrap)
    );

    // The vertical axis only steps on the horizontal wrap, so its wrap is the frame wrap.
    vga_axis_counter #(
        .TOTAL       (VER_TOTAL_TIME),
        .BLANK_START (VER_BLANK_START),
        .SYNC_START  (VER_SYNC_START),
        .SYNC_TIME   (VER_SYNC_TIME)
    ) u_vcnt (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (h_wrap),
        .cnt_o   (vcount),
        .blank_o (vblnk),
        .sync_o  (vsync),
        .wrap_o  (v_wrap)
    );

    always_comb begin
        frame_start_d = frame_start_q;
        if (en) begin
            frame_start_d = v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (v_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign frame_start = frame_start_q;
    assign out.hcount  = hcount;
    assign out.vcount  = vcount;
    assign out.hsync   = hsync;
    assign out.vsync   = vsync;
    assign out.hblnk   = hblnk;
    assign out.vblnk   = vblnk;
    assign out.rgb     = RGB_BLACK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: raster-position reference model plus directed checks.
// Covers the optional frame counter when VGA_TIMING_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;

    localparam int H_TOTAL   = 1056;
    localparam int V_TOTAL   = 628;
    localparam int FRAME_LEN = H_TOTAL * V_TOTAL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_if vif ();

    vga_timing_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .out         (vif),
        .frame_start (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fs_seen = 0;
    logic chk_on = 1'b0;
    logic [10:0] jump_h = '0;
    logic [10:0] jump_v = '0;

    // Reference model: linear position within the frame, strobe and frame count.
    int          m_pos    = 0;
    logic        m_strobe = 1'b0;
    logic [15:0] m_fcnt   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_pos    = 0;
            m_strobe = 1'b0;
            m_fcnt   = '0;
        end else if (en) begin
            m_pos    = (m_pos + 1) % FRAME_LEN;
            m_strobe = (m_pos == 0);
            if (m_strobe) m_fcnt = m_fcnt + 16'd1;
        end
    end

    always @(negedge clk) begin : cmp_proc
        int eh, ev;
        logic e_hb, e_hs, e_vb, e_vs, ok;
        if (chk_on) begin
            eh   = m_pos % H_TOTAL;
            ev   = m_pos / H_TOTAL;
            e_hb = (eh >= 800);
            e_hs = (eh >= 840) && (eh < 968);
            e_vb = (ev >= 600);
            e_vs = (ev >= 601) && (ev < 605);
            ok = (int'(vif.hcount) == eh) && (int'(vif.vcount) == ev) &&
                 (vif.hblnk == e_hb) && (vif.hsync == e_hs) &&
                 (vif.vblnk == e_vb) && (vif.vsync == e_vs) &&
                 (vif.rgb == 12'h000) && (frame_start == m_strobe);
`ifdef VGA_TIMING_FRAME_CNT_EN
            ok = ok && (frame_cnt == m_fcnt);
`endif
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got h=%0d v=%0d hb=%0b hs=%0b vb=%0b vs=%0b fs=%0b want h=%0d v=%0d hb=%0b hs=%0b vb=%0b vs=%0b fs=%0b",
                         $time, vif.hcount, vif.vcount, vif.hblnk, vif.hsync, vif.vblnk, vif.vsync,
                         frame_start, eh, ev, e_hb, e_hs, e_vb, e_vs, m_strobe);
            end
        end
    end

    always @(negedge clk) begin
        if (frame_start && en) fs_seen++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_h"},  int'(vif.hcount), 0);
        check({name, "_v"},  int'(vif.vcount), 0);
        check({name, "_fl"}, int'({vif.hsync, vif.vsync, vif.hblnk, vif.vblnk}), 0);
        check({name, "_rgb"}, int'(vif.rgb), 0);
        check({name, "_fs"}, int'(frame_start), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check({name, "_fc"}, int'(frame_cnt), 0);
`endif
    endtask

    // Teleport the raster to (h,v) with en low so the flags refresh from the new position.
    task automatic jump(input int h, input int v, input bit preload);
        chk_on = 1'b0;
        en     = 1'b0;
        rst    = 1'b0;
        jump_h = 11'(h);
        jump_v = 11'(v);
        force dut.u_hcnt.cnt_q = jump_h;
        force dut.u_vcnt.cnt_q = jump_v;
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (preload) force dut.frame_cnt_q = 16'hFFFF;
`endif
        @(negedge clk);
        release dut.u_hcnt.cnt_q;
        release dut.u_vcnt.cnt_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (preload) begin
            release dut.frame_cnt_q;
            m_fcnt = 16'hFFFF;
        end
`endif
        m_pos  = v * H_TOTAL + h;
        chk_on = 1'b1;
        en     = 1'b1;
    endtask

    initial begin
        run(3);
        check_all_zero("rst_en0");
        en = 1'b1;
        run(2);
        check_all_zero("rst_en1");
        chk_on = 1'b1;
        rst    = 1'b0;

        // First line after reset release.
        run(1);
        check("first_h", int'(vif.hcount), 1);
        check("first_v", int'(vif.vcount), 0);
        check("first_fl", int'({vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, frame_start}), 0);
        run(798);
        check("h799_hblnk", int'(vif.hblnk), 0);
        run(1);
        check("h800_h", int'(vif.hcount), 800);
        check("h800_hblnk", int'(vif.hblnk), 1);
        run(39);
        check("h839_hsync", int'(vif.hsync), 0);
        run(1);
        check("h840_hsync", int'(vif.hsync), 1);
        run(127);
        check("h967_hsync", int'(vif.hsync), 1);
        run(1);
        check("h968_hsync", int'(vif.hsync), 0);
        run(87);
        check("h1055_h", int'(vif.hcount), 1055);
        run(1);
        check("line_wrap_h", int'(vif.hcount), 0);
        check("line_wrap_v", int'(vif.vcount), 1);

        // Vertical blanking and sync window.
        jump(1050, 599, 1'b0);
        run(5);
        check("v599_vblnk", int'(vif.vblnk), 0);
        run(1);
        check("v600_vblnk", int'(vif.vblnk), 1);
        check("v600_vsync", int'(vif.vsync), 0);
        run(H_TOTAL);
        check("v601_vsync", int'(vif.vsync), 1);
        run(4 * H_TOTAL - 1);
        check("v604_end_vsync", int'(vif.vsync), 1);
        run(1);
        check("v605_v", int'(vif.vcount), 605);
        check("v605_vsync", int'(vif.vsync), 0);

        // Frame wrap strobe.
        jump(1050, 627, 1'b0);
        run(5);
        check("pre_wrap_fs", int'(frame_start), 0);
        run(1);
        check("wrap_h", int'(vif.hcount), 0);
        check("wrap_v", int'(vif.vcount), 0);
        check("wrap_fs", int'(frame_start), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("wrap_fcnt", int'(frame_cnt), 1);
`endif
        run(1);
        check("post_wrap_fs", int'(frame_start), 0);

        // Enable stall right before hsync.
        jump(835, 601, 1'b0);
        run(4);
        check("stall_pre_hsync", int'(vif.hsync), 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run(1);
            check("stall_h", int'(vif.hcount), 839);
            check("stall_v", int'(vif.vcount), 601);
            check("stall_fl", int'({vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, frame_start}), 5'b01110);
        end
        en = 1'b1;
        run(1);
        check("resume_h", int'(vif.hcount), 840);
        check("resume_hsync", int'(vif.hsync), 1);

        // Mid-frame reset.
        jump(495, 300, 1'b0);
        run(5);
        check("pre_rst_h", int'(vif.hcount), 500);
        check("pre_rst_v", int'(vif.vcount), 300);
        rst = 1'b1;
        run(1);
        check_all_zero("midrst");
        rst = 1'b0;

        // Three frames after reset.
        fs_seen = 0;
        for (int f = 0; f < 3; f++) begin
            jump(1000, 627, 1'b0);
            run(56);
            check("soak_fs", int'(frame_start), 1);
            run(2);
        end
        check("soak_fs_count", fs_seen, 3);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("soak_fcnt", int'(frame_cnt), 3);

        // Frame counter wraps from all-ones.
        jump(1050, 627, 1'b1);
        run(5);
        check("preload_fcnt", int'(frame_cnt), 16'hFFFF);
        run(1);
        check("fcnt_wrap", int'(frame_cnt), 0);
        check("fcnt_wrap_fs", int'(frame_start), 1);
`endif

        // Randomised positions, enable gaps and occasional resets.
        for (int s = 0; s < 10; s++) begin
            jump($urandom_range(0, 1055), (s % 2 == 1) ? $urandom_range(625, 627) : $urandom_range(0, 627), 1'b0);
            repeat ($urandom_range(300, 1500)) begin
                @(negedge clk);
                en  = ($urandom_range(0, 3) != 0);
                rst = ($urandom_range(0, 499) == 0);
            end
            @(negedge clk);
            rst = 1'b0;
        end
        run(2);
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
